// File: rtl/cg_addr_sequencer_if.sv
// Control and address bundle for the CG address sequencer.
// The master drives the pulses and steps; the slave returns addresses and status.
interface cg_addr_sequencer_if #(
    parameter int ADDR_W  = 20,
    parameter int NUM_VCH = 4,
    parameter int ITER_W  = 11
);
    logic                      start;
    logic                      phase_done;
    logic                      converged;
    logic                      mat_step;
    logic [NUM_VCH-1:0]        vrd_step;
    logic [NUM_VCH-1:0]        vwr_valid;
    logic [ADDR_W-1:0]         mat_rd_addr;
    logic [NUM_VCH*ADDR_W-1:0] vrd_addr;
    logic [NUM_VCH*ADDR_W-1:0] vwr_addr;
    logic [NUM_VCH-1:0]        vwr_en;
    logic [NUM_VCH-1:0]        vrd_wrap;
    logic [ITER_W-1:0]         iter_count;
    logic                      busy;
    logic                      halt;
    logic                      iter_done;

    modport master (
        output start, phase_done, converged, mat_step, vrd_step, vwr_valid,
        input  mat_rd_addr, vrd_addr, vwr_addr, vwr_en, vrd_wrap, iter_count, busy, halt, iter_done
    );

    modport slave (
        input  start, phase_done, converged, mat_step, vrd_step, vwr_valid,
        output mat_rd_addr, vrd_addr, vwr_addr, vwr_en, vrd_wrap, iter_count, busy, halt, iter_done
    );
endinterface

// File: rtl/cg_addr_sequencer.sv
// Address sequencer for a CG solver: matrix/P cluster reads, per-channel vector
// read/write addressing, phase and iteration bookkeeping with a RUN/HALT control FSM.
module cg_addr_sequencer #(
    parameter int ADDR_W          = 20,
    parameter int NUM_CLUSTERS    = 40,
    parameter int VEC_WORDS       = 3,
    parameter int NUM_VCH         = 4,
    parameter int PHASES_PER_ITER = 5,
    parameter int MAX_ITER        = 20,
    parameter int ITER_W          = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    cg_addr_sequencer_if.slave   bus
);

    localparam int                PH_W       = (PHASES_PER_ITER > 1) ? $clog2(PHASES_PER_ITER) : 1;
    localparam logic [ADDR_W-1:0] MAT_LAST   = ADDR_W'(NUM_CLUSTERS - 1);
    localparam logic [ADDR_W-1:0] WORD_LAST  = ADDR_W'(VEC_WORDS - 1);
    localparam logic [PH_W-1:0]   PHASE_LAST = PH_W'(PHASES_PER_ITER - 1);
    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] ITER_SAT   = {ITER_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] value,
                                                   input logic [ADDR_W-1:0] last);
        logic [ADDR_W-1:0] result;
        if (value == last) begin
            result = {ADDR_W{1'b0}};
        end else begin
            result = value + ADDR_W'(1);
        end
        return result;
    endfunction

    state_t                         state_r;
    state_t                         state_next_s;
    logic [PH_W-1:0]                phase_r;
    logic [PH_W-1:0]                phase_next_s;
    logic [ITER_W-1:0]              iter_count_r;
    logic [ITER_W-1:0]              iter_sat_next_s;
    logic                           iter_inc_s;
    logic                           restart_s;
    logic [ADDR_W-1:0]              mat_addr_r;
    logic [NUM_VCH-1:0][ADDR_W-1:0] vrd_cnt_r;
    logic [NUM_VCH-1:0][ADDR_W-1:0] vwr_cnt_r;
    logic [NUM_VCH-1:0][ADDR_W-1:0] vwr_addr_r;
    logic [NUM_VCH-1:0]             vwr_en_r;
    logic [NUM_VCH-1:0]             vrd_wrap_r;
    logic                           iter_done_r;
    logic                           busy_r;
    logic                           halt_r;

    // Next-state, phase advance and iteration-completion decode
    always_comb begin
        state_next_s    = state_r;
        phase_next_s    = phase_r;
        iter_inc_s      = 1'b0;
        restart_s       = 1'b0;
        iter_sat_next_s = (iter_count_r == ITER_SAT) ? iter_count_r : iter_count_r + ITER_W'(1);
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    state_next_s = ST_RUN;
                    restart_s    = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RUN: begin
                if (bus.phase_done) begin
                    if (phase_r == PHASE_LAST) begin
                        phase_next_s = {PH_W{1'b0}};
                        iter_inc_s   = 1'b1;
                    end else begin
                        phase_next_s = phase_r + PH_W'(1);
                    end
                end else begin
                    phase_next_s = phase_r;
                end
                // converged completes the iteration; a coinciding last phase counts only once
                if (bus.converged) begin
                    iter_inc_s   = 1'b1;
                    state_next_s = ST_HALT;
                end else if (iter_inc_s && (iter_sat_next_s == ITER_LIMIT)) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Address counters, write pipeline, phase/iteration counters and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            mat_addr_r   <= {ADDR_W{1'b0}};
            vrd_cnt_r    <= '0;
            vwr_cnt_r    <= '0;
            vwr_addr_r   <= '0;
            vwr_en_r     <= {NUM_VCH{1'b0}};
            vrd_wrap_r   <= {NUM_VCH{1'b0}};
            phase_r      <= {PH_W{1'b0}};
            iter_count_r <= {ITER_W{1'b0}};
            iter_done_r  <= 1'b0;
            busy_r       <= 1'b0;
            halt_r       <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_RUN);
            halt_r <= (state_next_s == ST_HALT);
            if (restart_s) begin
                mat_addr_r   <= {ADDR_W{1'b0}};
                vrd_cnt_r    <= '0;
                vwr_cnt_r    <= '0;
                vwr_addr_r   <= '0;
                vwr_en_r     <= {NUM_VCH{1'b0}};
                vrd_wrap_r   <= {NUM_VCH{1'b0}};
                phase_r      <= {PH_W{1'b0}};
                iter_count_r <= {ITER_W{1'b0}};
                iter_done_r  <= 1'b0;
            end else if (state_r == ST_RUN) begin
                phase_r     <= phase_next_s;
                iter_done_r <= iter_inc_s;
                if (iter_inc_s) begin
                    iter_count_r <= iter_sat_next_s;
                end
                if (bus.phase_done) begin
                    mat_addr_r <= {ADDR_W{1'b0}};
                    vrd_cnt_r  <= '0;
                    vwr_cnt_r  <= '0;
                    vwr_en_r   <= {NUM_VCH{1'b0}};
                    vrd_wrap_r <= {NUM_VCH{1'b0}};
                end else if (bus.converged) begin
                    // leaving for HALT: addresses freeze where they are
                    vwr_en_r   <= {NUM_VCH{1'b0}};
                    vrd_wrap_r <= {NUM_VCH{1'b0}};
                end else begin
                    if (bus.mat_step) begin
                        mat_addr_r <= wrap_inc(mat_addr_r, MAT_LAST);
                    end
                    for (int i = 0; i < NUM_VCH; i++) begin
                        vrd_wrap_r[i] <= bus.vrd_step[i] && (vrd_cnt_r[i] == WORD_LAST);
                        if (bus.vrd_step[i]) begin
                            vrd_cnt_r[i] <= wrap_inc(vrd_cnt_r[i], WORD_LAST);
                        end
                        vwr_en_r[i] <= bus.vwr_valid[i];
                        if (bus.vwr_valid[i]) begin
                            vwr_addr_r[i] <= vwr_cnt_r[i];
                            vwr_cnt_r[i]  <= wrap_inc(vwr_cnt_r[i], WORD_LAST);
                        end
                    end
                end
            end else begin
                vwr_en_r    <= {NUM_VCH{1'b0}};
                vrd_wrap_r  <= {NUM_VCH{1'b0}};
                iter_done_r <= 1'b0;
            end
        end
    end

    assign bus.mat_rd_addr = mat_addr_r;
    assign bus.vrd_addr    = vrd_cnt_r;
    assign bus.vwr_addr    = vwr_addr_r;
    assign bus.vwr_en      = vwr_en_r;
    assign bus.vrd_wrap    = vrd_wrap_r;
    assign bus.iter_count  = iter_count_r;
    assign bus.busy        = busy_r;
    assign bus.halt        = halt_r;
    assign bus.iter_done   = iter_done_r;

endmodule

// File: doc/cg_addr_sequencer.md
CG_ADDR_SEQUENCER -- requirements
Module: cg_addr_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 ADDR_W, 20, address width of every address port.
 NUM_CLUSTERS, 40, matrix/P cluster rows read per phase.
 VEC_WORDS, 3, words per vector memory, i.e. ceil(equations/units).
 NUM_VCH, 4, vector channels (P, Pv2, R, X).
 PHASES_PER_ITER, 5, phase_done pulses per CG iteration.
 MAX_ITER, 20, iteration limit.
 ITER_W, 11, iteration counter width.
REQ-002 Ports (name, direction, width, meaning), one per line:
 clk, in, 1, clock; reset reset, synchronous, active-high.
 reset, in, 1, reset (as stated in the line above).
 start, in, 1, pulse that begins a solve.
 phase_done, in, 1, pulse marking the end of an ALU phase.
 converged, in, 1, pulse meaning the residual is below threshold.
 mat_step, in, 1, advance the matrix/P cluster read address.
 vrd_step, in, NUM_VCH, per-channel vector read advance.
 vwr_valid, in, NUM_VCH, per-channel vector write request.
 mat_rd_addr, out, ADDR_W, matrix and P cluster read address.
 vrd_addr, out, NUM_VCH*ADDR_W, flat read addresses; channel i occupies [i*ADDR_W +: ADDR_W].
 vwr_addr, out, NUM_VCH*ADDR_W, flat write addresses (registered).
 vwr_en, out, NUM_VCH, write enables (registered).
 vrd_wrap, out, NUM_VCH, one-cycle pulse when a read address wraps.
 iter_count, out, ITER_W, number of completed iterations.
 busy, out, 1, high in state RUN.
 halt, out, 1, high in state HALT.
 iter_done, out, 1, one-cycle pulse when an iteration completes.

Function
REQ-003 FSM states are IDLE, RUN and HALT.
 IDLE->RUN on start.
 RUN->HALT on converged, or when iteration completion makes iter_count equal MAX_ITER.
 HALT->RUN on start; this restart clears all counters, and iter_count becomes 0.
REQ-004 All step and valid inputs are ignored outside RUN. start is ignored in RUN.
REQ-005 mat_rd_addr increments by 1 on mat_step in RUN. From NUM_CLUSTERS-1 it wraps to 0 in the same step; it never reaches NUM_CLUSTERS.
REQ-006 Vector read channel i increments by 1 on vrd_step[i].
 From VEC_WORDS-1 it wraps to 0.
 vrd_wrap[i] pulses high in the cycle after the wrapping step.
REQ-007 On vwr_valid[i] in RUN, the next cycle has vwr_en[i]=1 and vwr_addr[i] equal to the write counter value before the increment. The write counter then advances with the same wrap rule as REQ-006. Latency is exactly 1 cycle.
REQ-008 Back-to-back vwr_valid gives consecutive addresses with no bubbles. Channels are fully independent.
REQ-009 phase_done in RUN clears mat_rd_addr, all read counters and all write counters to 0 on the next edge.
 phase_done overrides any step or valid on the same cycle.
 A vwr_en already registered from the previous cycle still completes.
REQ-010 A phase counter (0..PHASES_PER_ITER-1) increments on phase_done. On the PHASES_PER_ITER-th pulse:
 - the phase counter goes to 0;
 - iter_count increments;
 - iter_done pulses for 1 cycle.
REQ-011 converged in RUN causes HALT on the next edge and increments iter_count once, with iter_done pulsing. If phase_done arrives in the same cycle, iter_count still increments exactly once.
REQ-012 iter_count saturates at its maximum and never wraps.
REQ-013 In HALT, all addresses hold their values, vwr_en=0, vrd_wrap=0 and halt=1.

Reset
REQ-014 Synchronous reset forces the following on the next edge, overriding every other input including a mid-operation phase:
 - state IDLE;
 - all addresses 0;
 - vwr_en=0, vrd_wrap=0;
 - iter_count=0, phase counter=0;
 - busy=0, halt=0, iter_done=0.
REQ-015 No simulation-only constructs: no timing waits inside processes and no display statements.

Verification
REQ-016 The bench covers the following directed scenarios:
 - Defaults, start, then 45 mat_step -> mat_rd_addr runs 0..39, returns to 0, and ends at 5.
 - vrd_step[2] held for 4 cycles -> addresses 1, 2, 0, 1; vrd_wrap[2] pulses once, one cycle after the step that produced 0.
 - vwr_valid[3] for 3 consecutive cycles -> vwr_en[3] high for 3 cycles starting 1 cycle later; vwr_addr[3] reads 0, 1, 2.
 - phase_done together with mat_step at mat_rd_addr=7 -> mat_rd_addr=0 next cycle.
 - 100 phase_done pulses -> iter_count=20, halt=1, busy=0; a further start -> RUN with iter_count=0.
 - converged in the same cycle as the 5th phase_done -> iter_count +1 only, HALT.
 - reset asserted mid-RUN with all counters nonzero -> every output takes its REQ-014 value next cycle.
